// File: rtl/prg_ray_queue_pkg.sv
// prg_ray_queue_pkg: ray/vector/float types shared with the generator, screen constants, queue state enum
package prg_ray_queue_pkg;
  localparam int SCREEN_W = 64;
  localparam int SCREEN_H = 48;
  localparam int NUM_RAYS = SCREEN_W * SCREEN_H;
  localparam int RAY_ID_W = $clog2(NUM_RAYS);
  typedef logic [31:0] float_t;
  typedef struct packed {
    float_t x;
    float_t y;
    float_t z;
  } vector_t;
  typedef struct packed {
    vector_t origin;
    vector_t dir;
    logic [RAY_ID_W-1:0] rayID;
  } ray_t;
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} q_state_t;
endpackage

// File: rtl/prg_ray_queue_mem.sv
// ray_fifo_mem: DEPTH x ray_t storage; clk/we/waddr/wdata sync write, raddr/rdata combinational read, no data reset
module ray_fifo_mem
  import prg_ray_queue_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  ray_t                     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output ray_t                     rdata
);
  ray_t mem [DEPTH];
  always_ff @(posedge clk) if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/prg_ray_queue.sv
// prg_ray_queue: FWFT ray buffer; rayReady/prg_data/prg_done in, ray_valid/ray_out/ray_ready out, int_to_prg_stall/frame_done/count/overflow status
module prg_ray_queue
  import prg_ray_queue_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int STALL_MARGIN = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rayReady,
  input  ray_t                   prg_data,
  input  logic                   prg_done,
  output logic                   int_to_prg_stall,
  output logic                   ray_valid,
  output ray_t                   ray_out,
  input  logic                   ray_ready,
  output logic                   frame_done,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [CW-1:0] count_nxt;
  logic push, pop, full, wr_en;
  q_state_t state, state_nxt;
  ray_t head;
  assign push      = rayReady;
  assign ray_valid = count != '0;
  assign pop       = ray_valid & ray_ready;
  assign full      = count == CW'(DEPTH);
  assign wr_en     = push & (~full | pop);
  assign count_nxt = count + CW'(wr_en) - CW'(pop);
  ray_fifo_mem #(.DEPTH(DEPTH)) u_mem (
    .clk  (clk),
    .we   (wr_en),
    .waddr(wr_ptr),
    .wdata(prg_data),
    .raddr(rd_ptr),
    .rdata(head)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr           <= '0;
      wr_ptr           <= '0;
      count            <= '0;
      overflow         <= 1'b0;
      int_to_prg_stall <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count            <= count_nxt;
      overflow         <= overflow | (push & ~wr_en);
      int_to_prg_stall <= count_nxt >= CW'(DEPTH - STALL_MARGIN);
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = push ? RUN : IDLE;
      RUN:     if (prg_done) state_nxt = (count == '0 && !push) ? DONE : FLUSH;
      FLUSH:   state_nxt = count_nxt == '0 ? DONE : FLUSH;
      DONE:    state_nxt = push ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    frame_done = state == DONE;
    ray_out    = ray_valid ? head : '0;
  end
endmodule
